// File: rtl/cym_pkg.sv
// Shared types and constants for the measurement controller.
// The FSM state encoding, the result width and the error code loaded on timeout.
package cym_pkg;
   localparam int DATA_W = 22;
   localparam logic [DATA_W-1:0] ERR_CODE = 22'h3FFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GATE,
      ST_WAIT_DONE,
      ST_DISP,
      ST_HOLD
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction
endpackage

// File: rtl/cym_down_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// Latency: one cycle from load/decrement to the new count. Saturates at zero.
module cym_down_cnt #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cym_meas_ctrl.sv
// Sequences gate / wait-for-result / display handshake / hold for a frequency counter core.
// Latency: all outputs registered, one cycle after the sampled trigger/done/ack.
module cym_meas_ctrl
   import cym_pkg::*;
#(
   parameter int GATE_CYCLES    = 50000000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int HOLD_CYCLES    = 25000000
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              en,
   input  logic              single,
   output logic              meas_start,
   output logic              meas_gate,
   input  logic              meas_done,
   input  logic [DATA_W-1:0] meas_data,
   output logic [DATA_W-1:0] data_fx,
   output logic              disp_req,
   input  logic              disp_ack,
   output logic              timeout,
   output logic              busy
);
   localparam int CNT_MAX = max3(GATE_CYCLES, TIMEOUT_CYCLES, HOLD_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // Each phase loads N-1 and leaves when the counter reads zero, giving N cycles.
   localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_start;
   logic              r_gate;
   logic              r_disp;
   logic              r_timeout;
   logic              r_busy;
   logic [DATA_W-1:0] r_data;

   logic              w_start_nxt;
   logic              w_timeout_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_load;
   logic [CNT_W-1:0]  w_load_val;
   logic              w_dec;
   logic              w_zero;

   cym_down_cnt #(.W(CNT_W)) u_cnt (
      .i_clk      (sys_clk),
      .i_rst      (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_load_val    = '0;
      w_dec         = 1'b0;
      w_data_nxt    = r_data;
      w_timeout_nxt = r_timeout;
      case (r_state)
         ST_IDLE: begin
            if (en || single) begin
               w_state_nxt = ST_GATE;
               w_load      = 1'b1;
               w_load_val  = GATE_LD;
            end
         end
         ST_GATE: begin
            if (w_zero) begin
               w_state_nxt = ST_WAIT_DONE;
               w_load      = 1'b1;
               w_load_val  = TO_LD;
            end else begin
               w_dec = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            // A result arriving on the last timeout cycle takes priority over the error code.
            if (meas_done) begin
               w_state_nxt   = ST_DISP;
               w_load        = 1'b1;
               w_data_nxt    = meas_data;
               w_timeout_nxt = 1'b0;
            end else if (w_zero) begin
               w_state_nxt   = ST_DISP;
               w_load        = 1'b1;
               w_data_nxt    = ERR_CODE;
               w_timeout_nxt = 1'b1;
            end else begin
               w_dec = 1'b1;
            end
         end
         ST_DISP: begin
            if (disp_ack) begin
               w_state_nxt = ST_HOLD;
               w_load      = 1'b1;
               w_load_val  = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (w_zero) begin
               w_load = 1'b1;
               if (en) begin
                  w_state_nxt = ST_GATE;
                  w_load_val  = GATE_LD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_dec = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b1;
         end
      endcase
      w_start_nxt = (w_state_nxt == ST_GATE) && (r_state != ST_GATE);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_start   <= 1'b0;
         r_gate    <= 1'b0;
         r_disp    <= 1'b0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
         r_data    <= '0;
      end else begin
         r_start   <= w_start_nxt;
         r_gate    <= (w_state_nxt == ST_GATE);
         r_disp    <= (w_state_nxt == ST_DISP);
         r_timeout <= w_timeout_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_data    <= w_data_nxt;
      end
   end

   assign meas_start = r_start;
   assign meas_gate  = r_gate;
   assign disp_req   = r_disp;
   assign timeout    = r_timeout;
   assign busy       = r_busy;
   assign data_fx    = r_data;
endmodule

// File: tb/tb_cym_meas_ctrl.sv
// Bench for cym_meas_ctrl: expected display results are queued when a measurement is
// launched and checked when disp_req rises; per-cycle gate/start timing is checked inline.
module tb_cym_meas_ctrl;
   import cym_pkg::*;

   localparam int GC = 8;
   localparam int TC = 16;
   localparam int HC = 4;

   logic              sys_clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              single = 1'b0;
   logic              meas_done = 1'b0;
   logic              disp_ack = 1'b0;
   logic [DATA_W-1:0] meas_data = '0;
   logic              meas_start;
   logic              meas_gate;
   logic              disp_req;
   logic              timeout;
   logic              busy;
   logic [DATA_W-1:0] data_fx;

   int n_tests = 0;
   int n_fail = 0;
   int n_starts = 0;
   int exp_starts = 0;

   logic [DATA_W:0]   exp_q[$];
   logic              prev_req = 1'b0;
   logic [DATA_W-1:0] held_dat = '0;

   cym_meas_ctrl #(
      .GATE_CYCLES    (GC),
      .TIMEOUT_CYCLES (TC),
      .HOLD_CYCLES    (HC)
   ) dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .en         (en),
      .single     (single),
      .meas_start (meas_start),
      .meas_gate  (meas_gate),
      .meas_done  (meas_done),
      .meas_data  (meas_data),
      .data_fx    (data_fx),
      .disp_req   (disp_req),
      .disp_ack   (disp_ack),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Scoreboard: one queued result per display request; data must hold while requested.
   always @(negedge sys_clk) begin
      if (rst) begin
         prev_req = 1'b0;
      end else begin
         if (meas_start) n_starts++;
         if (disp_req && !prev_req) begin
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               logic [DATA_W:0] e;
               e = exp_q.pop_front();
               chk("sb_data", data_fx, e[DATA_W-1:0]);
               chk("sb_timeout", timeout, e[DATA_W]);
            end
            held_dat = data_fx;
         end else if (disp_req) begin
            chk("dat_stable", data_fx, held_dat);
         end
         prev_req = disp_req;
      end
   end

   // Cycle 0 is the cycle in which the trigger is driven (or the last HOLD cycle in free-run).
   // done_at = 0 means no meas_done at all.
   task automatic run_meas(input bit trig, input int done_at, input logic [DATA_W-1:0] val,
                           input bit drop_en);
      bit good;
      bit seen;
      int exp_lat;
      good    = (done_at >= GC + 1) && (done_at <= GC + TC);
      exp_lat = good ? done_at + 1 : GC + TC + 1;
      exp_q.push_back(good ? {1'b0, val} : {1'b1, ERR_CODE});
      exp_starts++;
      seen = 1'b0;
      if (trig) single = 1'b1;
      for (int c = 1; c <= GC + TC + 8; c++) begin
         tick();
         single    = 1'b0;
         meas_done = 1'b0;
         disp_ack  = 1'b0;
         if (disp_req) begin
            chk("disp_lat", c, exp_lat);
            chk("disp_to", timeout, !good);
            chk("disp_dat", data_fx, good ? val : ERR_CODE);
            seen = 1'b1;
            break;
         end
         chk("start", meas_start, c == 1);
         chk("gate", meas_gate, c <= GC);
         chk("busy", busy, 1);
         if (c == 2 && drop_en) en = 1'b0;
         if (c == 3) single = 1'b1;
         if (c == 4) disp_ack = 1'b1;
         if (c == 5) begin
            meas_done = 1'b1;
            meas_data = 22'd999;
         end
         if (c == done_at) begin
            meas_done = 1'b1;
            meas_data = val;
         end
      end
      chk("disp_seen", seen, 1);
   endtask

   // Entered in the first DISP cycle (D); ack driven in D+2, HOLD runs D+3..D+6.
   task automatic do_ack();
      tick();
      chk("req_hold1", disp_req, 1);
      tick();
      chk("req_hold2", disp_req, 1);
      disp_ack = 1'b1;
      tick();
      disp_ack = 1'b0;
      chk("req_drop", disp_req, 0);
      chk("hold_busy", busy, 1);
      repeat (HC - 1) tick();
      chk("hold_last", busy, 1);
      chk("hold_nostart", meas_start, 0);
      if (!en) begin
         tick();
         chk("idle_busy", busy, 0);
         chk("idle_start", meas_start, 0);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      en     = 1'b1;
      single = 1'b1;
      repeat (3) tick();
      chk("rst_start", meas_start, 0);
      chk("rst_gate", meas_gate, 0);
      chk("rst_req", disp_req, 0);
      chk("rst_to", timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", data_fx, 0);
      en     = 1'b0;
      single = 1'b0;

      // Trigger in the same cycle reset is released: accepted on the first edge.
      rst = 1'b0;
      run_meas(1, 12, 22'd12345, 0);
      do_ack();

      run_meas(1, 0, '0, 0);
      do_ack();
      run_meas(1, 11, 22'h2AAAA, 0);
      do_ack();
      run_meas(1, GC + TC, 22'h155, 0);
      do_ack();
      run_meas(1, GC + 1, 22'h3FFFFE, 0);
      do_ack();

      en = 1'b1;
      run_meas(0, 10, 22'd1, 0);
      do_ack();
      run_meas(0, 0, '0, 0);
      do_ack();
      run_meas(0, 13, 22'd3, 1);
      do_ack();
      repeat (10) tick();
      chk("stop_busy", busy, 0);
      chk("stop_starts", n_starts, exp_starts);

      // Reset in the middle of the gate window.
      single = 1'b1;
      exp_starts++;
      tick();
      single = 1'b0;
      repeat (2) tick();
      chk("pre_rst_gate", meas_gate, 1);
      rst = 1'b1;
      tick();
      chk("rstg_gate", meas_gate, 0);
      chk("rstg_busy", busy, 0);
      rst = 1'b0;

      // Reset during the display handshake.
      run_meas(1, 10, 22'h777, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("rstd_req", disp_req, 0);
      chk("rstd_data", data_fx, 0);
      chk("rstd_to", timeout, 0);
      chk("rstd_busy", busy, 0);
      rst = 1'b0;
      tick();

      run_meas(1, 9, 22'h1234, 0);
      do_ack();
      repeat (2) tick();
      chk("total_starts", n_starts, exp_starts);
      chk("sb_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cym_meas_ctrl.md
CYM_MEAS_CTRL -- requirements
Module: cym_meas_ctrl

Interface
REQ-001 SHALL take parameter GATE_CYCLES, default 50000000: gate window length in sys_clk cycles, legal range 2..2^26-1.
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 1000000: maximum cycles to wait for meas_done after the gate closes, minimum 1.
REQ-003 SHALL take parameter HOLD_CYCLES, default 25000000: dwell cycles after a display handshake before the next gate, minimum 1.
REQ-004 SHALL provide sys_clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL provide rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL provide en, input, 1 bit: free-run enable for continuous measurement.
REQ-007 SHALL provide single, input, 1 bit: one-cycle one-shot trigger.
REQ-008 SHALL provide meas_start, output, 1 bit: one-cycle pulse that clears the measurement core.
REQ-009 SHALL provide meas_gate, output, 1 bit: gate window level to the measurement core.
REQ-010 SHALL provide meas_done, input, 1 bit: one-cycle pulse when the core result is stable.
REQ-011 SHALL provide meas_data, input, 22 bits: core result.
REQ-012 SHALL provide data_fx, output, 22 bits: latched result for the display.
REQ-013 SHALL provide disp_req, output, 1 bit: display refresh request.
REQ-014 SHALL provide disp_ack, input, 1 bit: display accepted data_fx.
REQ-015 SHALL provide timeout, output, 1 bit: sticky flag set when the last measurement timed out.
REQ-016 SHALL provide busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement an FSM with the states IDLE, GATE, WAIT_DONE, DISP and HOLD.
REQ-018 In IDLE, when en=1 or single=1 is sampled, the FSM SHALL enter GATE on the next edge and pulse meas_start for exactly that first GATE cycle.
REQ-019 SHALL hold meas_gate high for exactly GATE_CYCLES consecutive cycles, starting in the cycle meas_start is high, and then enter WAIT_DONE.
REQ-020 In WAIT_DONE, meas_done=1 SHALL latch meas_data into data_fx, clear timeout and enter DISP on the next edge.
REQ-021 If TIMEOUT_CYCLES cycles elapse in WAIT_DONE without meas_done, the block SHALL load data_fx with 22'h3FFFFF, set timeout and enter DISP.
REQ-022 If meas_done coincides with the final timeout cycle, meas_done SHALL win.
REQ-023 meas_done outside WAIT_DONE SHALL be ignored.
REQ-024 In DISP, disp_req SHALL be high, and data_fx stable, until disp_ack is sampled high.
REQ-025 disp_req SHALL drop on the edge that samples disp_ack, and the FSM SHALL enter HOLD on that edge.
REQ-026 disp_ack outside DISP SHALL be ignored.
REQ-027 HOLD SHALL last HOLD_CYCLES cycles; it SHALL then go to GATE (with a meas_start pulse) if en=1, otherwise to IDLE.
REQ-028 single while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 Deasserting en during GATE, WAIT_DONE or DISP SHALL NOT abort the cycle; it only takes effect at the end of HOLD.
REQ-030 One shared down-counter SHALL serve GATE, WAIT_DONE and HOLD.
REQ-031 The counter SHALL be sized to the maximum of the three parameters and reloaded on each state entry.
REQ-032 The counter SHALL never wrap.

Reset
REQ-033 rst=1 SHALL, on the next edge, force the FSM to IDLE regardless of current state, including mid-gate and mid-handshake.
REQ-034 On reset, meas_start=0, meas_gate=0, disp_req=0, timeout=0, busy=0, data_fx=0 and the counter=0.
REQ-035 The first trigger SHALL be accepted on the first edge after rst returns to 0.

Structure
REQ-036 Package cym_pkg SHALL hold the FSM state enum, DATA_W=22 and the constant ERR_CODE=22'h3FFFFF.
REQ-037 Sub-module cym_down_cnt (load, load value, decrement, zero flag) SHALL implement the shared counter.
REQ-038 All outputs SHALL be registered.

Verification (GATE_CYCLES=8, TIMEOUT_CYCLES=16, HOLD_CYCLES=4)
REQ-039 Single-shot: single pulse at cycle 0 with en=0 SHALL produce meas_start at cycle 1 and meas_gate high for cycles 1-8. meas_done with meas_data=22'd12345 at cycle 12 SHALL give data_fx=12345 and disp_req high at cycle 13. disp_ack at cycle 15 SHALL drop disp_req at cycle 16 and return to IDLE at cycle 20.
REQ-040 Timeout: no meas_done after the gate SHALL set data_fx=22'h3FFFFF, timeout=1 and disp_req exactly 16 cycles after WAIT_DONE entry.
REQ-041 Timeout clear: a following good measurement SHALL clear timeout.
REQ-042 Free-run: en held high SHALL produce back-to-back cycles with meas_start exactly 4 cycles after each disp_ack edge.
REQ-043 Free-run stop: dropping en during GATE SHALL complete that cycle and then stay in IDLE.
REQ-044 Collisions: meas_done on the final timeout cycle SHALL give timeout=0 and data_fx=meas_data. single while busy SHALL add no extra meas_start.
REQ-045 Reset mid-operation: rst asserted mid-GATE and mid-DISP SHALL zero meas_gate and disp_req on the next edge.
REQ-046 Restart after reset: a single one cycle after rst release SHALL start a normal measurement.
